// File: rtl/assert_collector.sv
// Collects checker failures, reports the first one over a valid/ready
// handshake, then raises stop after a programmable drain delay.
module assert_collector #(
    parameter int NUM_SRC  = 8,
    parameter int TS_W     = 32,
    parameter int CNT_W    = 8,
    parameter int STOP_DLY = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [NUM_SRC-1:0]         fail,
    output logic                       rpt_valid,
    input  logic                       rpt_ready,
    output logic [$clog2(NUM_SRC)-1:0] rpt_id,
    output logic [TS_W-1:0]            rpt_ts,
    output logic                       rpt_multi,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic                       stop,
    input  logic                       clear
);

    localparam int ID_W = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE,
        REPORT,
        DRAIN,
        HALT
    } state_t;

    state_t             state;
    logic [TS_W-1:0]    ts;
    logic [3:0]         dly;
    logic [NUM_SRC-1:0] eff;
    logic               any_fail;
    logic               multi_now;
    logic [ID_W-1:0]    first_id;

    assign eff       = fail & {NUM_SRC{en}};
    assign any_fail  = |eff;
    // clearing the lowest set bit leaves something only if 2+ bits were set
    assign multi_now = |(eff & (eff - NUM_SRC'(1)));

    always_comb begin
        first_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eff[i]) first_id = ID_W'(i);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            ts        <= '0;
            dly       <= '0;
            rpt_valid <= 1'b0;
            rpt_id    <= '0;
            rpt_ts    <= '0;
            rpt_multi <= 1'b0;
            fail_cnt  <= '0;
            stop      <= 1'b0;
        end else begin
            ts <= ts + TS_W'(1);
            if (any_fail && fail_cnt != '1) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (any_fail) begin
                        rpt_id    <= first_id;
                        rpt_ts    <= ts;
                        rpt_multi <= multi_now;
                        rpt_valid <= 1'b1;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (any_fail) rpt_multi <= 1'b1;
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        dly       <= 4'(STOP_DLY);
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (any_fail) rpt_multi <= 1'b1;
                    if (dly == 4'd0) begin
                        stop  <= 1'b1;
                        state <= HALT;
                    end else begin
                        dly <= dly - 4'd1;
                    end
                end
                HALT: begin
                    if (any_fail) rpt_multi <= 1'b1;
                    // clear wins over a coincident failure
                    if (clear) begin
                        stop      <= 1'b0;
                        fail_cnt  <= '0;
                        rpt_multi <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_assert_collector.sv
// Directed bench for assert_collector: default instance plus a
// CNT_W=4 instance sharing the same stimulus for saturation.
module tb_assert_collector;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       en;
    logic [7:0] fail;
    logic       rpt_ready;
    logic       clear;

    logic        rpt_valid, rpt_multi, stop;
    logic [2:0]  rpt_id;
    logic [31:0] rpt_ts;
    logic [7:0]  fail_cnt;

    logic        rpt_valid4, rpt_multi4, stop4;
    logic [2:0]  rpt_id4;
    logic [31:0] rpt_ts4;
    logic [3:0]  fail_cnt4;

    int checks = 0;
    int errors = 0;
    int ts     = 0;
    int t0;
    int t_stop;

    assert_collector dut (
        .clock(clock), .reset_n(reset_n), .en(en), .fail(fail),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_id(rpt_id),
        .rpt_ts(rpt_ts), .rpt_multi(rpt_multi), .fail_cnt(fail_cnt),
        .stop(stop), .clear(clear)
    );

    assert_collector #(.CNT_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .en(en), .fail(fail),
        .rpt_valid(rpt_valid4), .rpt_ready(rpt_ready), .rpt_id(rpt_id4),
        .rpt_ts(rpt_ts4), .rpt_multi(rpt_multi4), .fail_cnt(fail_cnt4),
        .stop(stop4), .clear(clear)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // ts tracks the DUT cycle counter value for the cycle now in progress
    task automatic tick();
        @(posedge clock);
        if (!reset_n) ts = 0;
        else ts = ts + 1;
        #1;
    endtask

    task automatic wait_stop(output int t);
        for (int i = 0; i < 30; i++) begin
            if (stop) break;
            tick();
        end
        chk("stop_reached", stop, 1);
        t = ts;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        en        = 1'b1;
        fail      = 8'hFF;
        rpt_ready = 1'b1;
        clear     = 1'b0;
        tick();
        tick();
        chk("rst_valid", rpt_valid, 0);
        chk("rst_stop", stop, 0);
        chk("rst_cnt", fail_cnt, 0);
        chk("rst_multi", rpt_multi, 0);
        fail    = 8'h00;
        reset_n = 1'b1;

        // single failure at counter 10, consumer always ready
        while (ts < 10) tick();
        fail = 8'h20;
        tick();
        fail = 8'h00;
        chk("t1_ts_now", ts, 11);
        chk("t1_valid", rpt_valid, 1);
        chk("t1_id", rpt_id, 5);
        chk("t1_ts", rpt_ts, 10);
        chk("t1_multi", rpt_multi, 0);
        chk("t1_cnt", fail_cnt, 1);
        tick();
        chk("t1_hs", rpt_valid, 0);
        chk("t1_drain_stop", stop, 0);
        wait_stop(t_stop);
        chk("t1_stop_ts", t_stop, 10 + 3 + 4);
        chk("t1_cnt_end", fail_cnt, 1);
        do_clear();
        chk("t1_clr_stop", stop, 0);
        chk("t1_clr_cnt", fail_cnt, 0);

        // two simultaneous failures
        fail = 8'h24;
        tick();
        fail = 8'h00;
        chk("t2_valid", rpt_valid, 1);
        chk("t2_id", rpt_id, 2);
        chk("t2_multi", rpt_multi, 1);
        chk("t2_cnt", fail_cnt, 1);
        wait_stop(t_stop);
        do_clear();
        chk("t2_clr_multi", rpt_multi, 0);

        // disabled checks
        en   = 1'b0;
        fail = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t3_masked", {rpt_valid, stop, fail_cnt}, 0);
        end
        en   = 1'b1;
        fail = 8'h00;

        // consumer stalls; repeat failure and ignored clear
        rpt_ready = 1'b0;
        fail      = 8'h01;
        tick();
        t0   = ts - 1;
        fail = 8'h00;
        chk("t4_valid0", rpt_valid, 1);
        for (int i = 0; i < 9; i++) begin
            fail  = (i == 3) ? 8'h01 : 8'h00;
            clear = (i == 5);
            tick();
        end
        fail  = 8'h00;
        clear = 1'b0;
        chk("t4_valid", rpt_valid, 1);
        chk("t4_id", rpt_id, 0);
        chk("t4_ts", rpt_ts, t0);
        chk("t4_multi", rpt_multi, 1);
        chk("t4_cnt", fail_cnt, 2);
        // failure on the handshake edge
        rpt_ready = 1'b1;
        fail      = 8'h80;
        tick();
        fail = 8'h00;
        chk("t4_hs_valid", rpt_valid, 0);
        chk("t4_hs_id", rpt_id, 0);
        chk("t4_hs_cnt", fail_cnt, 3);
        chk("t4_hs_stop", stop, 0);
        wait_stop(t_stop);
        do_clear();

        // saturation on the narrow counter, then clear
        fail = 8'hFF;
        repeat (20) tick();
        fail = 8'h00;
        chk("t5_cnt4", fail_cnt4, 15);
        chk("t5_cnt8", fail_cnt, 20);
        chk("t5_stop4", stop4, 1);
        chk("t5_multi4", rpt_multi4, 1);
        do_clear();
        chk("t5_clr_cnt4", fail_cnt4, 0);
        chk("t5_clr_stop4", stop4, 0);
        chk("t5_clr_valid4", rpt_valid4, 0);
        chk("t5_clr_multi4", rpt_multi4, 0);

        // reset during DRAIN
        fail = 8'h01;
        tick();
        fail = 8'h00;
        tick();
        tick();
        chk("t6_in_drain", {rpt_valid, stop}, 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t6_valid", rpt_valid, 0);
        chk("t6_stop", stop, 0);
        chk("t6_cnt", fail_cnt, 0);
        chk("t6_id", rpt_id, 0);
        chk("t6_ts", rpt_ts, 0);
        chk("t6_multi", rpt_multi, 0);
        fail = 8'h02;
        tick();
        fail = 8'h00;
        chk("t6_new_id", rpt_id, 1);
        chk("t6_new_ts", rpt_ts, 0);
        chk("t6_new_valid", rpt_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
